// File: rtl/wram_bsram_responder.sv
// Shares one byte-laned 2**ADDR_W x 16 BSRAM between the NES CPU byte port and the RV toggle port.
// CPU has priority, except while a WRAM load is in progress, when RV goes first and CPU writes are dropped.
module wram_bsram_responder #(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic [12:0]           i_cpu_addr,
  input  logic                  i_cpu_read,
  input  logic                  i_cpu_write,
  input  logic [7:0]            i_cpu_din,
  output logic [7:0]            o_cpu_dout,
  output logic                  o_cpu_overrun,
  input  logic [22:0]           i_rv_addr,
  input  logic                  i_rv_word,
  input  logic [31:0]           i_rv_wdata,
  input  logic [1:0]            i_rv_ds,
  input  logic                  i_rv_we,
  input  logic                  i_rv_req,
  output logic                  o_rv_req_ack,
  output logic [15:0]           o_rv_dout,
  input  logic                  i_wram_load_ongoing
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CPU_RD = 2'd1;
  localparam logic [1:0] ST_RV_RD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              cpu_we_q, cpu_we_d;
  logic [12:0]       cpu_addr_q, cpu_addr_d;
  logic [7:0]        cpu_din_q, cpu_din_d;
  logic              rd_lane_q, rd_lane_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic              overrun_q, overrun_d;
  logic              rv_req_q, rv_req_d;
  logic              ack_q, ack_d;
  logic [15:0]       rv_dout_q, rv_dout_d;

  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic [15:0]       mem_rdata_q;
  logic [15:0]       mem [0:(1<<ADDR_W)-1];

  logic              rv_pend;
  logic              cpu_drop;
  logic              cpu_grant;

  logic              unused_rv_addr;
  assign unused_rv_addr = &{1'b0, i_rv_addr[22:ADDR_W+1], i_rv_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    cpu_pend_d = cpu_pend_q;
    cpu_we_d   = cpu_we_q;
    cpu_addr_d = cpu_addr_q;
    cpu_din_d  = cpu_din_q;
    rd_lane_d  = rd_lane_q;
    cpu_dout_d = cpu_dout_q;
    overrun_d  = overrun_q;
    rv_req_d   = i_rv_req;
    ack_d      = ack_q;
    rv_dout_d  = rv_dout_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = 2'b00;
    cpu_grant  = 1'b0;

    rv_pend  = rv_req_q ^ ack_q;
    // A CPU write pending during a load is thrown away, whatever the FSM is doing.
    cpu_drop = cpu_pend_q & cpu_we_q & i_wram_load_ongoing;

    case (state_q)
      ST_IDLE: begin
        if (cpu_pend_q && !cpu_drop && (!i_wram_load_ongoing || !rv_pend)) begin
          cpu_grant = 1'b1;
          mem_addr  = cpu_addr_q[ADDR_W:1];
          if (cpu_we_q) begin
            mem_wdata = {cpu_din_q, cpu_din_q};
            mem_be    = cpu_addr_q[0] ? 2'b10 : 2'b01;
          end else begin
            rd_lane_d = cpu_addr_q[0];
            state_d   = ST_CPU_RD;
          end
        end else if (rv_pend) begin
          mem_addr = {i_rv_addr[ADDR_W:2], i_rv_word};
          if (i_rv_we) begin
            mem_wdata = i_rv_word ? i_rv_wdata[31:16] : i_rv_wdata[15:0];
            mem_be    = i_rv_ds;
            ack_d     = ~ack_q;
          end else begin
            state_d = ST_RV_RD;
          end
        end
      end
      ST_CPU_RD: begin
        cpu_dout_d = rd_lane_q ? mem_rdata_q[15:8] : mem_rdata_q[7:0];
        state_d    = ST_IDLE;
      end
      ST_RV_RD: begin
        rv_dout_d = mem_rdata_q;
        ack_d     = ~ack_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cpu_grant || cpu_drop) cpu_pend_d = 1'b0;

    // A new strobe replaces whatever is pending, including an entry granted this cycle.
    if (i_cpu_read || i_cpu_write) begin
      cpu_pend_d = 1'b1;
      cpu_we_d   = i_cpu_write;
      cpu_addr_d = i_cpu_addr;
      cpu_din_d  = i_cpu_din;
      overrun_d  = overrun_q | cpu_pend_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= ST_IDLE;
      cpu_pend_q <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      rd_lane_q  <= 1'b0;
      cpu_dout_q <= 8'hFF;
      overrun_q  <= 1'b0;
      rv_req_q   <= 1'b0;
      ack_q      <= 1'b0;
      rv_dout_q  <= '0;
    end else begin
      state_q    <= state_d;
      cpu_pend_q <= cpu_pend_d;
      cpu_we_q   <= cpu_we_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      rd_lane_q  <= rd_lane_d;
      cpu_dout_q <= cpu_dout_d;
      overrun_q  <= overrun_d;
      rv_req_q   <= rv_req_d;
      ack_q      <= ack_d;
      rv_dout_q  <= rv_dout_d;
    end
  end

  // BSRAM contents survive reset; only the port logic above is cleared.
  always_ff @(posedge i_clk) begin
    if (mem_be[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
    if (mem_be[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
    mem_rdata_q <= mem[mem_addr];
  end

  assign o_cpu_dout    = cpu_dout_q;
  assign o_cpu_overrun = overrun_q;
  assign o_rv_req_ack  = ack_q;
  assign o_rv_dout     = rv_dout_q;

endmodule

// File: tb/tb_wram_bsram_responder.sv
// Directed bench for wram_bsram_responder: latency, arbitration, load-mode discard, overrun, reset abort.
module tb_wram_bsram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [12:0] cpu_addr;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_overrun;
  logic [22:0] rv_addr;
  logic        rv_word;
  logic [31:0] rv_wdata;
  logic [1:0]  rv_ds;
  logic        rv_we;
  logic        rv_req;
  logic        rv_ack;
  logic [15:0] rv_dout;
  logic        load;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wram_bsram_responder #(.ADDR_W(12), .INIT_FILE("")) dut (
    .i_clk               (clk),
    .i_resetn            (resetn),
    .i_cpu_addr          (cpu_addr),
    .i_cpu_read          (cpu_read),
    .i_cpu_write         (cpu_write),
    .i_cpu_din           (cpu_din),
    .o_cpu_dout          (cpu_dout),
    .o_cpu_overrun       (cpu_overrun),
    .i_rv_addr           (rv_addr),
    .i_rv_word           (rv_word),
    .i_rv_wdata          (rv_wdata),
    .i_rv_ds             (rv_ds),
    .i_rv_we             (rv_we),
    .i_rv_req            (rv_req),
    .o_rv_req_ack        (rv_ack),
    .o_rv_dout           (rv_dout),
    .i_wram_load_ongoing (load)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [12:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_din   = d;
    cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    tick();
  endtask

  task automatic cpu_rd_chk(input string tag, input logic [12:0] a, input logic [7:0] exp);
    cpu_addr = a;
    cpu_read = 1'b1;
    tick();
    cpu_read = 1'b0;
    tick();
    tick();
    check(tag, {8'h00, cpu_dout}, {8'h00, exp});
  endtask

  task automatic rv_issue(input logic [22:0] a, input logic w, input logic [31:0] wd,
                          input logic [1:0] ds, input logic we);
    rv_addr  = a;
    rv_word  = w;
    rv_wdata = wd;
    rv_ds    = ds;
    rv_we    = we;
    rv_req   = !rv_req;
  endtask

  task automatic rv_rd_chk(input string tag, input logic [22:0] a, input logic w, input logic [15:0] exp);
    rv_issue(a, w, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    check({tag, "_ack_early"}, {15'h0, rv_ack}, {15'h0, !rv_req});
    tick();
    check({tag, "_ack"}, {15'h0, rv_ack}, {15'h0, rv_req});
    check({tag, "_dout"}, rv_dout, exp);
  endtask

  initial begin
    resetn    = 1'b0;
    cpu_addr  = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_din   = '0;
    rv_addr   = '0;
    rv_word   = 1'b0;
    rv_wdata  = '0;
    rv_ds     = 2'b00;
    rv_we     = 1'b0;
    rv_req    = 1'b0;
    load      = 1'b0;

    tick();
    tick();
    check("rst_cpu_dout", {8'h00, cpu_dout}, 16'h00FF);
    check("rst_overrun", {15'h0, cpu_overrun}, 16'h0000);
    check("rst_ack", {15'h0, rv_ack}, 16'h0000);
    check("rst_rv_dout", rv_dout, 16'h0000);
    resetn = 1'b1;
    tick();

    // T1: CPU write then read, data visible exactly three cycles after the read strobe
    cpu_wr(13'h0123, 8'hA5);
    cpu_addr = 13'h0123;
    cpu_read = 1'b1;
    tick();
    cpu_read = 1'b0;
    tick();
    check("t1_dout_n2", {8'h00, cpu_dout}, 16'h00FF);
    tick();
    check("t1_dout_n3", {8'h00, cpu_dout}, 16'h00A5);

    // T2: RV halfword write, acked two cycles after the toggle, then byte reads
    rv_issue(23'h066120, 1'b0, 32'h0000_1234, 2'b11, 1'b1);
    tick();
    check("t2_ack_n1", {15'h0, rv_ack}, 16'h0000);
    tick();
    check("t2_ack_n2", {15'h0, rv_ack}, 16'h0001);
    cpu_rd_chk("t2_lo", 13'h0120, 8'h34);
    cpu_rd_chk("t2_hi", 13'h0121, 8'h12);

    // RV read alone: ack and data three cycles after the toggle
    rv_rd_chk("rv_alone", 23'h066120, 1'b0, 16'h1234);

    // T3: CPU write and RV read together, CPU first, RV ack one cycle later than alone
    cpu_wr(13'h0125, 8'hC3);
    cpu_addr  = 13'h0124;
    cpu_din   = 8'h5A;
    cpu_write = 1'b1;
    rv_issue(23'h066124, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    cpu_write = 1'b0;
    tick();
    tick();
    check("t3_ack_n3", {15'h0, rv_ack}, {15'h0, !rv_req});
    tick();
    check("t3_ack_n4", {15'h0, rv_ack}, {15'h0, rv_req});
    check("t3_rv_dout", rv_dout, 16'hC35A);

    // T4: during a load the RV write goes first and the CPU write is dropped
    cpu_wr(13'h0001, 8'h77);
    load      = 1'b1;
    cpu_addr  = 13'h0000;
    cpu_din   = 8'h55;
    cpu_write = 1'b1;
    rv_issue(23'h066000, 1'b0, 32'h0000_BEEF, 2'b01, 1'b1);
    tick();
    cpu_write = 1'b0;
    check("t4_ack_n1", {15'h0, rv_ack}, {15'h0, !rv_req});
    tick();
    check("t4_ack_n2", {15'h0, rv_ack}, {15'h0, rv_req});
    cpu_rd_chk("t4_lo", 13'h0000, 8'hEF);
    cpu_rd_chk("t4_hi", 13'h0001, 8'h77);

    // T5: back-to-back CPU reads behind an RV read: overrun, only the second is served
    cpu_addr = 13'h0123;
    cpu_read = 1'b1;
    rv_issue(23'h066120, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    check("t5_overrun_n1", {15'h0, cpu_overrun}, 16'h0000);
    cpu_addr = 13'h0120;
    tick();
    cpu_read = 1'b0;
    check("t5_overrun_n2", {15'h0, cpu_overrun}, 16'h0001);
    tick();
    check("t5_ack_n3", {15'h0, rv_ack}, {15'h0, rv_req});
    check("t5_rv_dout", rv_dout, 16'h1234);
    tick();
    check("t5_dout_n4", {8'h00, cpu_dout}, 16'h0077);
    tick();
    check("t5_dout_n5", {8'h00, cpu_dout}, 16'h0034);
    load = 1'b0;

    rv_rd_chk("hw0", 23'h066000, 1'b0, 16'h77EF);

    // T6: reset during RV_RD aborts the read; a fresh request afterwards completes
    rv_issue(23'h066120, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    tick();
    resetn = 1'b0;
    rv_req = 1'b0;
    #1;
    check("t6_ack_rst", {15'h0, rv_ack}, 16'h0000);
    check("t6_dout_rst", {8'h00, cpu_dout}, 16'h00FF);
    check("t6_overrun_rst", {15'h0, cpu_overrun}, 16'h0000);
    check("t6_rv_dout_rst", rv_dout, 16'h0000);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    check("t6_ack_idle", {15'h0, rv_ack}, 16'h0000);
    rv_rd_chk("t6_after", 23'h066120, 1'b0, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
